p2s_lanes: RTL and testbench
============================

# p2s_lanes

Parametrised parallel-to-serial converter, successor to the single-bit `p2s` block. It accepts `N`-bit words on a valid/ready parallel port and emits them as `N/W` beats of `W` bits on a valid/ready serial port, with a selectable bit order and an end-of-word marker. An optional holding register lets the block accept the next word while the current one is still shifting, so the serial stream has no gap between words. It sits between word-oriented producers and narrow serial links or lane muxes.

## Interface
- `N`, 8, parallel word width. `N % W == 0` is required; elaboration fails otherwise.
- `W`, 1, serial beat width (lane count).
- `MSB_FIRST`, 0, beat order: 0 sends LSB beat first, 1 sends MSB beat first.
- `clk` in 1, single clock; all logic is on its rising edge.
- `rstn` in 1, reset; asynchronous, active-low.
- `p_data` in N, parallel word.
- `p_valid` in 1, `p_data` is valid.
- `p_ready` out 1, block accepts a word. This is a registered output.
- `s_data` out W, current serial beat.
- `s_valid` out 1, `s_data` is valid.
- `s_ready` in 1, the downstream consumer takes the beat.
- `s_last` out 1, the current beat is the final beat of its word.

## Operation
- `B = N/W` beats per word. The beat counter is `max(1, $clog2(B))` bits wide and counts 0..B-1.
- A parallel transfer occurs when `p_valid && p_ready`. A serial transfer occurs when `s_valid && s_ready`.
- States:
  - `IDLE`: shifter empty, `s_valid = 0`.
  - `SHIFT`: shifter holds a word, `s_valid = 1`.
- `IDLE` → `SHIFT`: on a parallel transfer. The word is loaded into the shifter and the counter is set to 0.
- In `SHIFT`, on each serial transfer:
  - The shifter moves by W bits (right if LSB-first, left if MSB-first).
  - The counter increments.
- `s_data` is the shifter's `[W-1:0]` slice when LSB-first, or its `[N-1 -: W]` slice when MSB-first.
- `s_last = s_valid && (cnt == B-1)`.
- When the last beat transfers:
  - If a next word is available, it is loaded, the counter is set to 0, and the state stays `SHIFT`.
  - Otherwise the state goes to `IDLE`.
- While `s_valid && !s_ready`, `s_data` and `s_last` hold stable. No beat is dropped or duplicated.
- `B == 1` is a degenerate case: every beat has `s_last = 1`.

## Timing
- Reset values: `p_ready = 0`, `s_valid = 0`, `s_last = 0`, `s_data = 0`. The shifter, counter and holding register are all cleared.
- `p_ready` first rises on the first rising edge after `rstn` is released.
- Latency: `s_valid` rises in the cycle after the parallel transfer.
- `p_ready` never depends combinationally on `s_ready` or `p_valid`.
- Reset asserted mid-word: all outputs drop to their reset values immediately. The in-flight word and any held word are discarded. No partial word is resumed after reset.
- `p_valid` asserted while `p_ready = 0`: no transfer happens. The producer must hold `p_data`.

## Configuration
- Macro: `P2S_LANES_DBUF_EN`.
- Defined — one-word holding register:
  - `p_ready` is the registered value of `!hold_full`.
  - A word accepted while the block is in `IDLE`, or in the same cycle as a last-beat transfer with the holding register empty, goes straight to the shifter.
  - Otherwise the accepted word goes to the holding register.
  - On a last-beat transfer, a full holding register moves into the shifter.
  - Result: back-to-back words produce a continuous serial stream with zero gap cycles.
- Not defined — no holding register:
  - `p_ready` is registered `(next_state == IDLE)`.
  - Between consecutive words there is exactly one cycle with `s_valid = 0`.

## Structure
- Package `p2s_pkg` holds:
  - the `IDLE`/`SHIFT` state enum;
  - a `beats(N, W)` function;
  - a `cnt_w(N, W)` function.
- Sub-module `p2s_shifter` contains the shift register, the beat counter and the `s_data`/`s_last` generation. It takes `N`, `W` and `MSB_FIRST` as parameters and has load and advance strobes. The top level owns the FSM, the ready logic and the optional holding register.

## Test plan
- Reset release, with N=8 and W=1: `p_ready` is 0 during reset and 1 one edge after `rstn` rises. `s_valid`, `s_last` and `s_data` all stay 0.
- N=8, W=1, LSB-first, `p_data = 62`, `s_ready = 1`: `s_data` = 0,1,1,1,1,1,0,0 on 8 consecutive cycles. `s_last` is high only on the 8th beat. `s_valid` drops afterwards.
- N=8, W=2, MSB-first, `p_data = 8'hB4`: beats are 2,3,1,0, with `s_last` on the 4th beat.
- Back-pressure: `p_data = 52` with `s_ready` pulled low for 3 cycles after beat 2. `s_data` holds the value of beat 3 for those 3 cycles. All 8 beats (0,0,1,0,1,1,0,0) are delivered exactly once.
- Back-to-back words 62 then 52, `s_ready = 1`:
  - With `P2S_LANES_DBUF_EN`: 16 contiguous beats, no `s_valid` gap.
  - Without it: exactly one idle cycle between the 8th and 9th beats.
- `rstn` pulsed low during beat 3 of word 62: outputs go to 0 asynchronously. After release, word 7 is serialised from beat 0 as 1,1,1,0,0,0,0,0.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and elaboration helpers for the p2s_lanes parallel-to-serial block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package p2s_pkg;

  // Converter state: IDLE means the shifter is empty, SHIFT means a word is being emitted.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of W-bit beats needed to carry one N-bit word.
  function automatic int beats(input int n, input int w);
    return n / w;
  endfunction

  // Beat counter width; at least one bit even when a word is a single beat.
  function automatic int cnt_w(input int n, input int w);
    int b;
    b = n / w;
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/p2s_shifter.sv
// Shift register plus beat counter that turns one N-bit word into N/W beats of W bits.
// Latency: a loaded word appears on o_data the cycle after i_load.
// Backpressure: contents hold while i_adv is low, so o_data/o_last stay stable.
module p2s_shifter
  import p2s_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  input  logic         i_adv,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_last
);

  localparam int B  = beats(N, W);
  localparam int CW = cnt_w(N, W);
  localparam logic [CW-1:0] LAST_CNT = CW'(B - 1);

  logic [N-1:0]  r_sh;
  logic [CW-1:0] r_cnt;

  // Load restarts the word at beat 0 and wins over advance (last beat + next word).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (i_adv) begin
      r_sh  <= (MSB_FIRST != 0) ? (r_sh << W) : (r_sh >> W);
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
    end
  end

  // The outgoing beat always sits at the end of the register that shifts out first.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign o_data = r_sh[N-1 -: W];
    end else begin : g_lsb
      assign o_data = r_sh[W-1:0];
    end
  endgenerate

  assign o_last = i_valid && (r_cnt == LAST_CNT);

endmodule

// File: rtl/p2s_lanes.sv
// Parallel-to-serial converter: N-bit words out as N/W beats of W bits with s_last on the final beat.
// Latency: s_valid rises the cycle after a parallel transfer; optional macro P2S_LANES_DBUF_EN adds a holding register for gapless streaming.
// Backpressure: s_ready low freezes the current beat; p_ready is registered and never combinational on s_ready/p_valid.
module p2s_lanes
  import p2s_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] p_data,
  input  logic         p_valid,
  output logic         p_ready,
  output logic [W-1:0] s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         s_last
);

  generate
    if (W < 1 || (N % W) != 0) begin : g_bad_width
      $error("p2s_lanes: N must be a positive multiple of W");
    end
  endgenerate

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_p_ready;
  logic         w_p_xfer;
  logic         w_s_xfer;
  logic         w_last_xfer;
  logic         w_load;
  logic [N-1:0] w_load_data;

  assign s_valid     = (r_state == SHIFT);
  assign p_ready     = r_p_ready;
  assign w_p_xfer    = p_valid && r_p_ready;
  assign w_s_xfer    = s_valid && s_ready;
  assign w_last_xfer = w_s_xfer && s_last;

`ifdef P2S_LANES_DBUF_EN
  logic         r_hold_full;
  logic         w_hold_full_nxt;
  logic         w_hold_wr;
  logic [N-1:0] r_hold;

  // Route each accepted word to the shifter or the holding register and pick the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_load_data     = p_data;
    w_hold_full_nxt = r_hold_full;
    w_hold_wr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_p_xfer) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_xfer) begin
          if (r_hold_full) begin
            // p_ready is low whenever the hold is full, so no new word competes here.
            w_load          = 1'b1;
            w_load_data     = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_p_xfer) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_p_xfer) begin
          w_hold_wr       = 1'b1;
          w_hold_full_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding register captures a word that arrives while the shifter is still busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_hold_full <= w_hold_full_nxt;
      if (w_hold_wr) begin
        r_hold <= p_data;
      end
    end
  end

  // State and ready register; ready tracks free space in the holding register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_p_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_p_ready <= !w_hold_full_nxt;
    end
  end
`else
  // Without a holding register a word is only accepted while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = p_data;
    case (r_state)
      IDLE: begin
        if (w_p_xfer) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_xfer) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and ready register; ready is asserted exactly while the next state is idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_p_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_p_ready <= (w_state_nxt == IDLE);
    end
  end
`endif

  p2s_shifter #(
    .N         (N),
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_adv   (w_s_xfer),
    .i_valid (s_valid),
    .o_data  (s_data),
    .o_last  (s_last)
  );

endmodule

// File: tb/tb_p2s_lanes.sv
`timescale 1ns/1ps
// Bench for p2s_lanes: directed cases plus randomized traffic against a word-to-beat queue model.
// Two instances: A is N=8 W=1 LSB-first, B is N=8 W=2 MSB-first.
// Build with P2S_LANES_DBUF_EN defined to exercise the gapless holding-register variant.
module tb_p2s_lanes;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] a_pdata, b_pdata;
  logic       a_pvalid, a_pready, a_svalid, a_sready, a_slast;
  logic       b_pvalid, b_pready, b_svalid, b_sready, b_slast;
  logic [0:0] a_sdata;
  logic [1:0] b_sdata;

  p2s_lanes #(.N(8), .W(1), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rstn(rstn), .p_data(a_pdata), .p_valid(a_pvalid), .p_ready(a_pready),
    .s_data(a_sdata), .s_valid(a_svalid), .s_ready(a_sready), .s_last(a_slast)
  );

  p2s_lanes #(.N(8), .W(2), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rstn(rstn), .p_data(b_pdata), .p_valid(b_pvalid), .p_ready(b_pready),
    .s_data(b_sdata), .s_valid(b_svalid), .s_ready(b_sready), .s_last(b_slast)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Beat k of a word, encoded as data | (last << 8).
  function automatic int model_beat(input int word, input int w, input bit msb, input int k);
    int b, idx;
    b   = 8 / w;
    idx = msb ? (b - 1 - k) : k;
    return ((word >> (idx * w)) & ((1 << w) - 1)) | ((k == b - 1) ? 256 : 0);
  endfunction

  int a_exp[$], a_obs[$], a_cyc[$];
  int b_exp[$], b_obs[$], b_cyc[$];
  bit a_stall = 0, b_stall = 0;
  int a_prev = 0, b_prev = 0;

  // Monitor A: stall stability, beat-vs-model scoreboard, and model push on accept.
  always @(negedge clk) begin
    int got, want;
    if (!rstn) begin
      a_exp.delete();
      a_stall = 0;
    end else begin
      got = int'(a_sdata) | (a_slast ? 256 : 0);
      if (a_stall) begin
        check("a_stall_valid", a_svalid, 1);
        check("a_stall_beat", got, a_prev);
      end
      if (a_svalid && a_sready) begin
        a_obs.push_back(got);
        a_cyc.push_back(cyc);
        check("a_beat_expected", a_exp.size() > 0, 1);
        if (a_exp.size() > 0) begin
          want = a_exp.pop_front();
          check("a_beat", got, want);
        end
      end
      a_stall = a_svalid && !a_sready;
      a_prev  = got;
      if (a_pvalid && a_pready)
        for (int k = 0; k < 8; k++) a_exp.push_back(model_beat(a_pdata, 1, 0, k));
    end
  end

  // Monitor B: same scoreboard for the 2-lane MSB-first instance.
  always @(negedge clk) begin
    int got, want;
    if (!rstn) begin
      b_exp.delete();
      b_stall = 0;
    end else begin
      got = int'(b_sdata) | (b_slast ? 256 : 0);
      if (b_stall) begin
        check("b_stall_valid", b_svalid, 1);
        check("b_stall_beat", got, b_prev);
      end
      if (b_svalid && b_sready) begin
        b_obs.push_back(got);
        b_cyc.push_back(cyc);
        check("b_beat_expected", b_exp.size() > 0, 1);
        if (b_exp.size() > 0) begin
          want = b_exp.pop_front();
          check("b_beat", got, want);
        end
      end
      b_stall = b_svalid && !b_sready;
      b_prev  = got;
      if (b_pvalid && b_pready)
        for (int k = 0; k < 4; k++) b_exp.push_back(model_beat(b_pdata, 2, 1, k));
    end
  end

  task automatic send_a(input logic [7:0] w);
    bit ok;
    ok       = 0;
    a_pdata  = w;
    a_pvalid = 1'b1;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (a_pready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    a_pvalid = 1'b0;
    check("a_send_accepted", ok, 1);
  endtask

  task automatic send_b(input logic [7:0] w);
    bit ok;
    ok       = 0;
    b_pdata  = w;
    b_pvalid = 1'b1;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (b_pready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    b_pvalid = 1'b0;
    check("b_send_accepted", ok, 1);
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while ((a_exp.size() != 0 || a_svalid) && t < 600) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("a_drained", a_exp.size(), 0);
    check("a_idle_after_drain", a_svalid, 0);
  endtask

  task automatic drain_b();
    int t;
    t = 0;
    while ((b_exp.size() != 0 || b_svalid) && t < 600) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("b_drained", b_exp.size(), 0);
    check("b_idle_after_drain", b_svalid, 0);
  endtask

  task automatic check_seq(input string tag, input int got[$], input int want[$]);
    check({tag, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) check(tag, got[i], want[i]);
  endtask

  task automatic wait_a_beats(input int n);
    int t;
    t = 0;
    while (a_obs.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("a_wait_beats", a_obs.size() >= n, 1);
  endtask

  int want[$];
  int gap_exp;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_pvalid = 0; b_pvalid = 0; a_pdata = 0; b_pdata = 0;
    a_sready = 1; b_sready = 1; rstn = 0;

    // Reset values and release timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_p_ready", a_pready, 0);
    check("rst_a_s_valid", a_svalid, 0);
    check("rst_a_s_last", a_slast, 0);
    check("rst_a_s_data", a_sdata, 0);
    check("rst_b_p_ready", b_pready, 0);
    check("rst_b_s_data", b_sdata, 0);
    #2 rstn = 1;
    #1 check("rel_p_ready_before_edge", a_pready, 0);
    @(posedge clk);
    #1;
    check("rel_a_p_ready", a_pready, 1);
    check("rel_b_p_ready", b_pready, 1);
    check("rel_a_s_valid", a_svalid, 0);
    check("rel_a_s_last", a_slast, 0);
    check("rel_a_s_data", a_sdata, 0);

    // Word 62, LSB-first single lane.
    a_obs.delete(); a_cyc.delete();
    send_a(8'd62);
    drain_a();
    want = '{0, 1, 1, 1, 1, 1, 0, 256};
    check_seq("w62_seq", a_obs, want);
    if (a_cyc.size() == 8) check("w62_contiguous", a_cyc[7] - a_cyc[0], 7);

    // Word 8'hB4, MSB-first two lanes.
    b_obs.delete(); b_cyc.delete();
    send_b(8'hB4);
    drain_b();
    want = '{2, 3, 1, 256};
    check_seq("wb4_seq", b_obs, want);

    // Back-pressure: stall three cycles after beat 2 of word 52.
    a_obs.delete(); a_cyc.delete();
    send_a(8'd52);
    wait_a_beats(2);
    #1 a_sready = 0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_valid", a_svalid, 1);
      check("bp_hold_data", a_sdata, 1);
      check("bp_hold_last", a_slast, 0);
    end
    @(posedge clk);
    #1 a_sready = 1;
    drain_a();
    want = '{0, 0, 1, 0, 1, 1, 0, 256};
    check_seq("bp_seq", a_obs, want);

    // Back-to-back words 62 then 52.
    a_obs.delete(); a_cyc.delete();
    send_a(8'd62);
    send_a(8'd52);
    drain_a();
    want = '{0, 1, 1, 1, 1, 1, 0, 256, 0, 0, 1, 0, 1, 1, 0, 256};
    check_seq("b2b_seq", a_obs, want);
`ifdef P2S_LANES_DBUF_EN
    gap_exp = 1;
`else
    gap_exp = 2;
`endif
    if (a_cyc.size() == 16) begin
      check("b2b_word1_span", a_cyc[7] - a_cyc[0], 7);
      check("b2b_word_gap", a_cyc[8] - a_cyc[7], gap_exp);
      check("b2b_word2_span", a_cyc[15] - a_cyc[8], 7);
    end

    // Reset pulse during beat 3 of word 62, then word 7 from scratch.
    a_obs.delete(); a_cyc.delete();
    send_a(8'd62);
    wait_a_beats(2);
    #3 rstn = 0;
    #1;
    check("mid_rst_s_valid", a_svalid, 0);
    check("mid_rst_s_data", a_sdata, 0);
    check("mid_rst_s_last", a_slast, 0);
    check("mid_rst_p_ready", a_pready, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rstn = 1;
    a_obs.delete(); a_cyc.delete();
    send_a(8'd7);
    drain_a();
    want = '{1, 1, 1, 0, 0, 0, 0, 256};
    check_seq("post_rst_seq", a_obs, want);

    // Randomized traffic on both instances with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send_a(8'($urandom_range(0, 255)));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send_b(8'($urandom_range(0, 255)));
        end
      end
      begin
        repeat (1500) begin
          @(posedge clk);
          #1;
          a_sready = 1'($urandom_range(0, 1));
          b_sready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #1;
    a_sready = 1;
    b_sready = 1;
    drain_a();
    drain_b();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
